multicycle_control: RTL and testbench

- Multicycle control sequencer for the DataPath.
- It sits directly upstream of the enabled registers (PC, IR, register-file write port and the 1-bit flag registers).
- It generates their single-cycle writeEnable pulses and the mux selects that steer their D inputs.
- It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and stalls on a memory ready handshake.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_output_decode.sv | 71 +++++++
 rtl/multicycle_control.sv | 125 ++++++++++++
 tb/tb_multicycle_control.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control sequencer.
// Optional illegal-opcode trapping is enabled with the ILLEGAL_TRAP_EN macro.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_WB     = 4'd5,
    S_HALT   = 4'd6,
    S_TRAP   = 4'd7
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_INC = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  typedef enum logic [2:0] {
    OPC_ALU, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_HALT, OPC_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] pcSrc;
    logic [1:0] aluOp;
    logic       wbSel;
  } ctrl_out_t;

  function automatic op_class_t classify(input logic [3:0] op);
    case (op)
      OP_ALU:  return OPC_ALU;
      OP_ADDI: return OPC_ADDI;
      OP_LW:   return OPC_LW;
      OP_SW:   return OPC_SW;
      OP_BEQ:  return OPC_BEQ;
      OP_J:    return OPC_J;
      OP_HALT: return OPC_HALT;
      default: return OPC_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational decode of state/opcode/flags into the datapath enables and mux selects.
// Also exports the opcode class so the sequencer and the decoder agree on it.
module ctrl_output_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  state_t          state,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            memReady,
  input  logic            wbSelReg,
  output op_class_t       opClass,
  output ctrl_out_t       ctrl
);

  logic [3:0] opLow;
  logic       opHigh;

  // Any set bit above the 4-bit opcode space makes the opcode illegal.
  if (OPW > 4) begin : gWide
    assign opLow  = opcode[3:0];
    assign opHigh = |opcode[OPW-1:4];
  end else begin : gNarrow
    assign opLow  = 4'(opcode);
    assign opHigh = 1'b0;
  end

  assign opClass = opHigh ? OPC_ILLEGAL : classify(opLow);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        if (memReady) begin
          ctrl.irWrite = 1'b1;
          ctrl.pcWrite = 1'b1;
          ctrl.pcSrc   = PCSRC_INC;
        end
      end
      S_DECODE: begin
        if (opClass == OPC_J) begin
          ctrl.pcWrite = 1'b1;
          ctrl.pcSrc   = PCSRC_JMP;
        end
      end
      S_EXEC: begin
        case (opClass)
          OPC_ALU:                   ctrl.aluOp = ALUOP_FUNCT;
          OPC_ADDI, OPC_LW, OPC_SW:  ctrl.aluOp = ALUOP_ADD;
          OPC_BEQ: begin
            ctrl.aluOp   = ALUOP_SUB;
            ctrl.pcSrc   = PCSRC_BR;
            ctrl.pcWrite = zero;
          end
          default: ;
        endcase
      end
      S_MEMRD: ctrl.memRead  = 1'b1;
      S_MEMWR: ctrl.memWrite = 1'b1;
      S_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.wbSel    = wbSelReg;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready stalls.
// Define ILLEGAL_TRAP_EN to send illegal opcodes to an absorbing TRAP state.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic           clock,
  input  logic           resetN,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           memReady,
  output logic           pcWrite,
  output logic           irWrite,
  output logic           regWrite,
  output logic           memRead,
  output logic           memWrite,
  output logic [1:0]     pcSrc,
  output logic [1:0]     aluOp,
  output logic           wbSel,
  output logic           halted,
  output logic           memTimeout,
  output logic [3:0]     stateDbg
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  state_t          state;
  logic [WCW-1:0]  waitCnt;
  logic            wbSelReg;
  logic            haltedReg;
  logic            memTimeoutReg;
  op_class_t       opClass;
  ctrl_out_t       decOut;
  ctrl_out_t       gatedOut;
  logic            waiting;

  ctrl_output_decode #(.OPW(OPW)) uDecode (
    .state    (state),
    .opcode   (opcode),
    .zero     (zero),
    .memReady (memReady),
    .wbSelReg (wbSelReg),
    .opClass  (opClass),
    .ctrl     (decOut)
  );

  assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= S_FETCH;
      waitCnt       <= '0;
      wbSelReg      <= 1'b0;
      haltedReg     <= 1'b0;
      memTimeoutReg <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wbSelReg <= (state == S_MEMRD) && memReady;

      // Waiting states only leave on memReady, so clearing on memReady also covers state changes.
      if (waiting && !memReady) begin
        if (waitCnt != WCW'(MAX_WAIT)) waitCnt <= waitCnt + WCW'(1);
        else                           memTimeoutReg <= 1'b1;
      end else begin
        waitCnt <= '0;
      end

      case (state)
        S_FETCH: if (memReady) state <= S_DECODE;
        S_DECODE: begin
          case (opClass)
            OPC_ALU, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ: state <= S_EXEC;
            OPC_J: state <= S_FETCH;
            OPC_HALT: begin
              state     <= S_HALT;
              haltedReg <= 1'b1;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state     <= S_TRAP;
              haltedReg <= 1'b1;
`else
              state     <= S_FETCH;
`endif
            end
          endcase
        end
        S_EXEC: begin
          case (opClass)
            OPC_ALU, OPC_ADDI: state <= S_WB;
            OPC_LW:            state <= S_MEMRD;
            OPC_SW:            state <= S_MEMWR;
            default:           state <= S_FETCH;
          endcase
        end
        S_MEMRD: if (memReady) state <= S_WB;
        S_MEMWR: if (memReady) state <= S_FETCH;
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:  state <= S_TRAP;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  // Requests and enables drop the moment resetN falls, not at the next edge.
  assign gatedOut = resetN ? decOut : '0;

  assign pcWrite    = gatedOut.pcWrite;
  assign irWrite    = gatedOut.irWrite;
  assign regWrite   = gatedOut.regWrite;
  assign memRead    = gatedOut.memRead;
  assign memWrite   = gatedOut.memWrite;
  assign pcSrc      = gatedOut.pcSrc;
  assign aluOp      = gatedOut.aluOp;
  assign wbSel      = gatedOut.wbSel;
  assign halted     = haltedReg;
  assign memTimeout = memTimeoutReg;
  assign stateDbg   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// instruction streams compared against a per-cycle expectation built from the instruction rules.
module tb_multicycle_control;

  localparam int MAX_WAIT = 15;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC   = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWR  = 4'd4;
  localparam logic [3:0] ST_WB     = 4'd5;
  localparam logic [3:0] ST_HALT   = 4'd6;
  localparam logic [3:0] ST_TRAP   = 4'd7;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       memReady = 1'b1;
  logic       pcWrite, irWrite, regWrite, memRead, memWrite, wbSel, halted, memTimeout;
  logic [1:0] pcSrc, aluOp;
  logic [3:0] stateDbg;

  multicycle_control #(.OPW(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .opcode     (opcode),
    .zero       (zero),
    .memReady   (memReady),
    .pcWrite    (pcWrite),
    .irWrite    (irWrite),
    .regWrite   (regWrite),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .pcSrc      (pcSrc),
    .aluOp      (aluOp),
    .wbSel      (wbSel),
    .halted     (halted),
    .memTimeout (memTimeout),
    .stateDbg   (stateDbg)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rdy;
    logic [3:0] st;
    logic       pcW, irW, rgW, mRd, mWr;
    logic [1:0] pcSrc, aluOp;
    logic       wbSel, hlt;
  } cyc_t;

  cyc_t expQ[$];
  logic expTo = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [3:0] legalOps [6] = '{OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};

  function automatic logic [15:0] observed();
    return {stateDbg, pcWrite, irWrite, regWrite, memRead, memWrite, pcSrc, aluOp,
            wbSel, halted, memTimeout};
  endfunction

  function automatic logic [15:0] expv(input cyc_t c);
    return {c.st, c.pcW, c.irW, c.rgW, c.mRd, c.mWr, c.pcSrc, c.aluOp, c.wbSel, c.hlt, expTo};
  endfunction

  function automatic cyc_t blank(input logic [3:0] st, input logic rdy);
    cyc_t c = '0;
    c.st  = st;
    c.rdy = rdy;
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, with fw fetch stalls and mw memory stalls.
  task automatic build(input logic [3:0] op, input logic z, input int fw, input int mw);
    cyc_t c;
    for (int i = 0; i < fw; i++) begin
      c = blank(ST_FETCH, 1'b0); c.mRd = 1'b1; expQ.push_back(c);
    end
    c = blank(ST_FETCH, 1'b1); c.mRd = 1'b1; c.irW = 1'b1; c.pcW = 1'b1; expQ.push_back(c);
    c = blank(ST_DECODE, rnd());
    case (op)
      OP_J: begin
        c.pcW = 1'b1; c.pcSrc = 2'd2; expQ.push_back(c);
      end
      OP_HALT: begin
        expQ.push_back(c);
        for (int i = 0; i < 4; i++) begin
          c = blank(ST_HALT, rnd()); c.hlt = 1'b1; expQ.push_back(c);
        end
      end
      OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
        expQ.push_back(c);
        c = blank(ST_EXEC, rnd());
        if (op == OP_ALU) c.aluOp = 2'd2;
        else if (op == OP_BEQ) begin c.aluOp = 2'd1; c.pcSrc = 2'd1; c.pcW = z; end
        else c.aluOp = 2'd0;
        expQ.push_back(c);
        if (op == OP_LW || op == OP_SW) begin
          for (int i = 0; i <= mw; i++) begin
            c = blank(op == OP_LW ? ST_MEMRD : ST_MEMWR, i == mw);
            c.mRd = (op == OP_LW); c.mWr = (op == OP_SW);
            expQ.push_back(c);
          end
        end
        if (op == OP_ALU || op == OP_ADDI || op == OP_LW) begin
          c = blank(ST_WB, rnd()); c.rgW = 1'b1; c.wbSel = (op == OP_LW); expQ.push_back(c);
        end
      end
      default: begin
        expQ.push_back(c);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
          c = blank(ST_TRAP, rnd()); c.hlt = 1'b1; expQ.push_back(c);
        end
`endif
      end
    endcase
  endtask

  // Called at a negedge; drives memReady, samples 1ns later, then moves to the next negedge.
  task automatic runQ(input string tag, input int limit);
    cyc_t c;
    int   n = 0;
    while (expQ.size() > 0 && n < limit) begin
      c = expQ.pop_front();
      memReady = c.rdy;
      #1;
      check($sformatf("%s[%0d]", tag, n), observed(), expv(c));
      @(negedge clock);
      n++;
    end
    expQ.delete();
  endtask

  task automatic runInstr(input string tag, input logic [3:0] op, input logic z,
                          input int fw, input int mw);
    cyc_t c;
    opcode = op;
    zero   = z;
    build(op, z, fw, mw);
    if (op != OP_HALT) begin
      c = blank(ST_FETCH, 1'b0); c.mRd = 1'b1; expQ.push_back(c);
    end
    runQ(tag, 1000);
  endtask

  task automatic doReset(input string tag);
    resetN   = 1'b0;
    memReady = 1'b1;
    expTo    = 1'b0;
    #1;
    check(tag, observed(), expv(blank(ST_FETCH, 1'b1)));
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    cyc_t c;
    // Reset state with memReady high: nothing may leak through.
    @(negedge clock);
    check("reset", observed(), expv(blank(ST_FETCH, 1'b1)));
    resetN = 1'b1;

    runInstr("addi", OP_ADDI, 1'b0, 0, 0);
    runInstr("lw3", OP_LW, 1'b0, 0, 3);
    runInstr("beq_z1", OP_BEQ, 1'b1, 1, 0);
    runInstr("beq_z0", OP_BEQ, 1'b0, 0, 0);
    runInstr("jump", OP_J, 1'b1, 2, 0);
    runInstr("sw2", OP_SW, 1'b0, 0, 2);
    runInstr("alu", OP_ALU, 1'b1, 0, 0);
    runInstr("lw0", OP_LW, 1'b1, 1, 0);

    runInstr("illegal9", 4'h9, 1'b0, 0, 0);
    doReset("reset_after_illegal");

    for (int k = 0; k < 30; k++)
      runInstr($sformatf("rand%0d", k), legalOps[$urandom_range(0, 5)], rnd(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // Fetch stalled for 20 cycles: timeout once more than MAX_WAIT cycles have been waited.
    doReset("reset_before_timeout");
    for (int k = 0; k < 20; k++) begin
      memReady = 1'b0;
      expTo    = (k > MAX_WAIT);
      #1;
      c = blank(ST_FETCH, 1'b0); c.mRd = 1'b1;
      check($sformatf("timeout[%0d]", k), observed(), expv(c));
      @(negedge clock);
    end
    runInstr("sticky_addi", OP_ADDI, 1'b0, 0, 0);
    doReset("reset_clears_timeout");

    // Reset pulsed during a stalled store.
    opcode = OP_SW;
    build(OP_SW, 1'b0, 0, 6);
    runQ("sw_pre", 4);
    memReady = 1'b0;
    #1;
    c = blank(ST_MEMWR, 1'b0); c.mWr = 1'b1;
    check("sw_held", observed(), expv(c));
    resetN = 1'b0;
    #1;
    check("sw_reset_drop", observed(), expv(blank(ST_FETCH, 1'b0)));
    @(negedge clock);
    check("sw_in_reset", observed(), expv(blank(ST_FETCH, 1'b0)));
    resetN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      c = blank(ST_FETCH, 1'b0); c.mRd = 1'b1;
      check($sformatf("after_reset[%0d]", k), observed(), expv(c));
      @(negedge clock);
    end

    runInstr("halt", OP_HALT, 1'b0, 0, 0);
    doReset("reset_leaves_halt");
    runInstr("post_halt_addi", OP_ADDI, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
